// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: branch history table of 2^IDX_W saturating counters.
// Gives a same-cycle taken/not-taken prediction for the fetch PC and is trained
// with resolved outcomes from execute/writeback. The counter array has no reset.
// It is cleared by a sequential sweep, one entry per cycle, after reset or a flush.
// Optional feature: define BHT_GSHARE_EN to XOR a global history register into the index.
module branch_predictor_bht #(
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int PC_LSB = 2,
  parameter int GHR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pred_pc,
  output logic [IDX_W-1:0]  pred_idx,
  output logic [CTR_W-1:0]  pred_ctr,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              flush,
  output logic              busy
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   clr_idx;
  logic [IDX_W-1:0]   clr_idx_next;
  logic [CTR_W-1:0]   ctr_mem [DEPTH];
  logic [IDX_W-1:0]   pc_idx;
  logic               upd_accept;
  logic [CTR_W-1:0]   upd_old;
  logic [CTR_W-1:0]   upd_new;
  logic               unused_pc;

  // Counter increment that holds at the all-ones maximum.
  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
    sat_inc = (c == {CTR_W{1'b1}}) ? c : c + CTR_W'(1);
  endfunction

  // Counter decrement that holds at zero.
  function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
    sat_dec = (c == '0) ? c : c - CTR_W'(1);
  endfunction

  // Only a slice of the PC forms the index; the rest is deliberately ignored.
  assign unused_pc = ^pred_pc;
  assign pc_idx    = pred_pc[PC_LSB +: IDX_W];

  // A flush always beats a training update in the same cycle.
  assign upd_accept = (state == READY) && upd_valid && !flush;

`ifdef BHT_GSHARE_EN
  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] ghr_ext;

  // Global history: shift in each accepted outcome; cleared by reset and flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (flush) begin
      ghr <= '0;
    end else if (upd_accept) begin
      ghr <= {ghr[GHR_W-2:0], upd_taken};
    end
  end

  // Zero-extend the history to the index width before hashing.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr;
  end

  assign pred_idx = pc_idx ^ ghr_ext;
`else
  logic [GHR_W-1:0] unused_ghr_w;
  assign unused_ghr_w = '0;
  assign pred_idx     = pc_idx;
`endif

  // Sweep controller: CLEAR walks every entry once, then READY until flushed.
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      CLEAR: begin
        if (flush) begin
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx + IDX_W'(1);
          if (clr_idx == {IDX_W{1'b1}}) begin
            state_next = READY;
          end
        end
      end
      READY: begin
        if (flush) begin
          state_next   = CLEAR;
          clr_idx_next = '0;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_idx_next = '0;
      end
    endcase
  end

  // State and sweep pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // Training value computed from the stored counter of the entry being updated.
  assign upd_old = ctr_mem[upd_idx];
  assign upd_new = upd_taken ? sat_inc(upd_old) : sat_dec(upd_old);

  // Single write port: the sweep owns it while clearing, training otherwise.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      ctr_mem[clr_idx] <= '0;
    end else if (upd_accept) begin
      ctr_mem[upd_idx] <= upd_new;
    end
  end

  // Combinational read; a same-cycle write lands after this read.
  assign pred_ctr   = ctr_mem[pred_idx];
  assign pred_taken = (state == READY) && pred_ctr[CTR_W-1];
  assign busy       = (state == CLEAR);

endmodule
